fetch_seq_ctrl: RTL and testbench

FETCH_SEQ_CTRL -- requirements
Module: fetch_seq_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 61 ++++++
 rtl/fetch_seq_ctrl_if.sv | 38 +++
 rtl/fetch_seq_ctrl.sv | 86 ++++++++
 tb/tb_fetch_seq_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: fetch-sequencer states, pc_sel encodings
// and the per-state registered output pattern.
package pipe_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    CALL_PUSH = 4'd1,
    CALL_JMP  = 4'd2,
    RET_POP   = 4'd3,
    RTI_POP   = 4'd4,
    RTI_FLAGS = 4'd5,
    POP_WAIT  = 4'd6,
    POP_LOAD  = 4'd7,
    LDM_IMM   = 4'd8,
    INT_PUSH  = 4'd9,
    INT_FLAGS = 4'd10,
    INT_VEC   = 4'd11
  } state_t;

  localparam logic [1:0] PC_SEL_INC = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_STK = 2'b10;
  localparam logic [1:0] PC_SEL_VEC = 2'b11;

  typedef struct packed {
    logic       cs_call;
    logic       cs_ret;
    logic       cs_rti;
    logic       previous_rti;
    logic       fetch_nop;
    logic       cs_ldm;
    logic       pc_hold;
    logic [1:0] pc_sel;
    logic       int_ack;
    logic       busy;
  } ctrl_t;

  // Output pattern shown while sitting in state s (flush NOP is layered on top).
  function automatic ctrl_t state_outs(input state_t s);
    ctrl_t o;
    o        = '0;
    o.pc_sel = PC_SEL_INC;
    o.busy   = (s != IDLE);
    case (s)
      CALL_PUSH: begin o.cs_call = 1'b1; o.pc_hold = 1'b1; end
      CALL_JMP:  begin o.fetch_nop = 1'b1; o.pc_sel = PC_SEL_BR; end
      RET_POP:   begin o.cs_ret = 1'b1; o.pc_hold = 1'b1; end
      RTI_POP:   begin o.cs_rti = 1'b1; o.pc_hold = 1'b1; end
      RTI_FLAGS: begin o.previous_rti = 1'b1; o.pc_hold = 1'b1; end
      POP_WAIT:  begin o.fetch_nop = 1'b1; o.pc_hold = 1'b1; end
      POP_LOAD:  begin o.fetch_nop = 1'b1; o.pc_sel = PC_SEL_STK; end
      LDM_IMM:   begin o.fetch_nop = 1'b1; o.cs_ldm = 1'b1; end
      INT_PUSH:  begin o.int_ack = 1'b1; o.cs_call = 1'b1; o.pc_hold = 1'b1; end
      INT_FLAGS: begin o.fetch_nop = 1'b1; o.pc_hold = 1'b1; end
      INT_VEC:   begin o.fetch_nop = 1'b1; o.pc_sel = PC_SEL_VEC; end
      default:   o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/fetch_seq_ctrl_if.sv
// Trigger inputs and fetch-buffer override outputs of the fetch sequencer.
// Handshake: none; triggers are level-sampled at posedge, outputs are registered.
interface fetch_seq_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic       instr_valid;
  logic       is_call;
  logic       is_ret;
  logic       is_rti;
  logic       is_ldm;
  logic       stall;
  logic       flush;
  logic       int_req;

  logic       cs_call;
  logic       cs_ret;
  logic       cs_rti;
  logic       previous_rti;
  logic       fetch_NOP;
  logic       cs_ldm;
  logic       pc_hold;
  logic [1:0] pc_sel;
  logic       int_ack;
  logic       busy;
  state_t     dbg_state;

  modport master (
    output instr_valid, is_call, is_ret, is_rti, is_ldm, stall, flush, int_req,
    input  cs_call, cs_ret, cs_rti, previous_rti, fetch_NOP, cs_ldm,
    input  pc_hold, pc_sel, int_ack, busy, dbg_state
  );

  modport slave (
    input  instr_valid, is_call, is_ret, is_rti, is_ldm, stall, flush, int_req,
    output cs_call, cs_ret, cs_rti, previous_rti, fetch_NOP, cs_ldm,
    output pc_hold, pc_sel, int_ack, busy, dbg_state
  );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: multi-cycle CALL/RET/RTI/LDM/interrupt sequences as a Moore
// FSM whose outputs are registered from the next state.
module fetch_seq_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  fetch_seq_ctrl_if.slave  bus
);

  localparam logic [2:0] CNT_LOAD = 3'(MEM_LAT - 1);

  state_t     r_state;
  logic [2:0] r_cnt;
  ctrl_t      r_outs;

  state_t     w_nxt_state;
  logic [2:0] w_nxt_cnt;
  logic       w_flush_nop;
  ctrl_t      w_nxt_outs;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_flush_nop = 1'b0;
    case (r_state)
      IDLE: begin
        // stall is handled at the register; flush beats special beats int_req
        if (bus.flush)                          w_flush_nop = 1'b1;
        else if (bus.instr_valid && bus.is_call) w_nxt_state = CALL_PUSH;
        else if (bus.instr_valid && bus.is_ret)  w_nxt_state = RET_POP;
        else if (bus.instr_valid && bus.is_rti)  w_nxt_state = RTI_POP;
        else if (bus.instr_valid && bus.is_ldm)  w_nxt_state = LDM_IMM;
        else if (bus.int_req)                    w_nxt_state = INT_PUSH;
      end
      CALL_PUSH: w_nxt_state = CALL_JMP;
      CALL_JMP:  w_nxt_state = IDLE;
      RET_POP:   begin w_nxt_state = POP_WAIT; w_nxt_cnt = CNT_LOAD; end
      RTI_POP:   w_nxt_state = RTI_FLAGS;
      RTI_FLAGS: begin w_nxt_state = POP_WAIT; w_nxt_cnt = CNT_LOAD; end
      POP_WAIT: begin
        if (r_cnt == 3'd0) w_nxt_state = POP_LOAD;
        else               w_nxt_cnt   = r_cnt - 3'd1;
      end
      POP_LOAD:  w_nxt_state = IDLE;
      LDM_IMM:   w_nxt_state = IDLE;
      INT_PUSH:  w_nxt_state = INT_FLAGS;
      INT_FLAGS: w_nxt_state = INT_VEC;
      INT_VEC:   w_nxt_state = IDLE;
      default:   w_nxt_state = IDLE;
    endcase

    w_nxt_outs = state_outs(w_nxt_state);
    if (w_flush_nop) begin
      w_nxt_outs.fetch_nop = 1'b1;
      w_nxt_outs.pc_sel    = PC_SEL_BR;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_outs  <= '0;
    end else if (!bus.stall) begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_outs  <= w_nxt_outs;
    end
  end

  assign bus.cs_call      = r_outs.cs_call;
  assign bus.cs_ret       = r_outs.cs_ret;
  assign bus.cs_rti       = r_outs.cs_rti;
  assign bus.previous_rti = r_outs.previous_rti;
  assign bus.fetch_NOP    = r_outs.fetch_nop;
  assign bus.cs_ldm       = r_outs.cs_ldm;
  assign bus.pc_hold      = r_outs.pc_hold;
  assign bus.pc_sel       = r_outs.pc_sel;
  assign bus.int_ack      = r_outs.int_ack;
  assign bus.busy         = r_outs.busy;
  assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl (MEM_LAT=2); expected output patterns are
// hand-written 11-bit vectors.
module tb_fetch_seq_ctrl;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  fetch_seq_ctrl_if bus ();

  fetch_seq_ctrl #(.MEM_LAT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {cs_call, cs_ret, cs_rti, previous_rti, fetch_NOP, cs_ldm, pc_hold, pc_sel[1:0], int_ack, busy}
  logic [10:0] obs;
  assign obs = {bus.cs_call, bus.cs_ret, bus.cs_rti, bus.previous_rti, bus.fetch_NOP,
                bus.cs_ldm, bus.pc_hold, bus.pc_sel, bus.int_ack, bus.busy};

  localparam logic [10:0] O_IDLE      = 11'b0000_000_00_0_0;
  localparam logic [10:0] O_FLUSH     = 11'b0000_100_01_0_0;
  localparam logic [10:0] O_CALL_PUSH = 11'b1000_001_00_0_1;
  localparam logic [10:0] O_CALL_JMP  = 11'b0000_100_01_0_1;
  localparam logic [10:0] O_RET_POP   = 11'b0100_001_00_0_1;
  localparam logic [10:0] O_RTI_POP   = 11'b0010_001_00_0_1;
  localparam logic [10:0] O_RTI_FLAGS = 11'b0001_001_00_0_1;
  localparam logic [10:0] O_POP_WAIT  = 11'b0000_101_00_0_1;
  localparam logic [10:0] O_POP_LOAD  = 11'b0000_100_10_0_1;
  localparam logic [10:0] O_LDM       = 11'b0000_110_00_0_1;
  localparam logic [10:0] O_INT_PUSH  = 11'b1000_001_00_1_1;
  localparam logic [10:0] O_INT_FLAGS = 11'b0000_101_00_0_1;
  localparam logic [10:0] O_INT_VEC   = 11'b0000_100_11_0_1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [10:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.instr_valid = 1'b0;
    bus.is_call     = 1'b0;
    bus.is_ret      = 1'b0;
    bus.is_rti      = 1'b0;
    bus.is_ldm      = 1'b0;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    bus.int_req     = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    clear_inputs();

    // reset state
    #3;
    chk("reset_async", O_IDLE);
    step();
    step();
    reset = 1'b1;
    step();
    chk("idle_after_reset", O_IDLE);

    // CALL: trigger sampled at edge N -> CALL_PUSH, CALL_JMP, IDLE
    bus.instr_valid = 1'b1; bus.is_call = 1'b1;
    step(); chk("call_push", O_CALL_PUSH);
    clear_inputs();
    step(); chk("call_jmp", O_CALL_JMP);
    step(); chk("call_idle", O_IDLE);

    // RTI with MEM_LAT=2: busy for 5 cycles
    bus.instr_valid = 1'b1; bus.is_rti = 1'b1;
    step(); chk("rti_pop", O_RTI_POP);
    clear_inputs();
    step(); chk("rti_flags", O_RTI_FLAGS);
    step(); chk("rti_wait1", O_POP_WAIT);
    step(); chk("rti_wait2", O_POP_WAIT);
    step(); chk("rti_load", O_POP_LOAD);
    step(); chk("rti_idle", O_IDLE);

    // int_req raised during RET: accepted on the first IDLE cycle
    bus.instr_valid = 1'b1; bus.is_ret = 1'b1;
    step(); chk("ret_pop", O_RET_POP);
    clear_inputs();
    bus.int_req = 1'b1;
    step(); chk("ret_wait1", O_POP_WAIT);
    step(); chk("ret_wait2", O_POP_WAIT);
    step(); chk("ret_load", O_POP_LOAD);
    step(); chk("ret_idle_int_pend", O_IDLE);
    step(); chk("int_push", O_INT_PUSH);
    bus.int_req = 1'b0;
    step(); chk("int_flags", O_INT_FLAGS);
    step(); chk("int_vec", O_INT_VEC);
    step(); chk("int_idle", O_IDLE);

    // stall for 3 cycles inside POP_WAIT stretches RET by 3
    bus.instr_valid = 1'b1; bus.is_ret = 1'b1;
    step(); chk("sret_pop", O_RET_POP);
    clear_inputs();
    step(); chk("sret_wait1", O_POP_WAIT);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk("sret_frozen", O_POP_WAIT);
    end
    bus.stall = 1'b0;
    step(); chk("sret_wait2", O_POP_WAIT);
    step(); chk("sret_load", O_POP_LOAD);
    step(); chk("sret_idle", O_IDLE);

    // flush beats is_call in IDLE
    bus.flush = 1'b1; bus.instr_valid = 1'b1; bus.is_call = 1'b1;
    step(); chk("flush_over_call", O_FLUSH);
    clear_inputs();
    step(); chk("flush_then_idle", O_IDLE);

    // flush during CALL_PUSH is ignored
    bus.instr_valid = 1'b1; bus.is_call = 1'b1;
    step(); chk("fcall_push", O_CALL_PUSH);
    clear_inputs();
    bus.flush = 1'b1;
    step(); chk("fcall_jmp", O_CALL_JMP);
    bus.flush = 1'b0;
    step(); chk("fcall_idle", O_IDLE);

    // stall beats a special instruction in IDLE
    bus.stall = 1'b1; bus.instr_valid = 1'b1; bus.is_call = 1'b1;
    step(); chk("stall_idle", O_IDLE);
    clear_inputs();
    step(); chk("stall_idle_after", O_IDLE);

    // special beats int_req: LDM first, then the interrupt
    bus.instr_valid = 1'b1; bus.is_ldm = 1'b1; bus.int_req = 1'b1;
    step(); chk("ldm_imm", O_LDM);
    bus.instr_valid = 1'b0; bus.is_ldm = 1'b0;
    step(); chk("ldm_idle", O_IDLE);
    step(); chk("ldm_int_push", O_INT_PUSH);
    bus.int_req = 1'b0;
    step(); chk("ldm_int_flags", O_INT_FLAGS);
    step(); chk("ldm_int_vec", O_INT_VEC);
    step(); chk("ldm_int_idle", O_IDLE);

    // reset mid-RTI_FLAGS: outputs drop immediately
    bus.instr_valid = 1'b1; bus.is_rti = 1'b1;
    step(); chk("rrti_pop", O_RTI_POP);
    clear_inputs();
    step(); chk("rrti_flags", O_RTI_FLAGS);
    #2;
    reset = 1'b0;
    #1;
    chk("rrti_reset_async", O_IDLE);
    step();
    reset = 1'b1;
    step(); chk("rrti_idle_after", O_IDLE);
    bus.instr_valid = 1'b1; bus.is_ldm = 1'b1;
    step(); chk("rrti_resume_ldm", O_LDM);
    clear_inputs();
    step(); chk("rrti_resume_idle", O_IDLE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
